i2c_cmd_sequencer: RTL and testbench

I2C_CMD_SEQUENCER -- requirements
Module: i2c_cmd_sequencer

---
 rtl/i2c_seq_pkg.sv | 24 ++
 rtl/i2c_cmd_fifo.sv | 50 +++++
 rtl/i2c_cmd_sequencer.sv | 157 +++++++++++++++
 tb/tb_i2c_cmd_sequencer.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_seq_pkg.sv
// Shared types and default constants for the I2C command sequencer.
package i2c_seq_pkg;

   localparam int DEF_DEPTH          = 4;
   localparam int DEF_GAP_CYCLES     = 50;
   localparam int DEF_TIMEOUT_CYCLES = 2048;

   // One queued host command: direction, 7-bit target, write byte, master mode
   typedef struct packed {
      logic       wr;
      logic [6:0] addr;
      logic [7:0] data;
      logic [2:0] mode;
   } cmd_t;

   typedef enum logic [2:0] {
      IDLE,
      LAUNCH,
      WAIT_DONE,
      RESP,
      GAP
   } state_t;

endpackage

// File: rtl/i2c_cmd_fifo.sv
// Command FIFO for the I2C sequencer: power-of-two depth, wrap-bit pointers.
// A push while full is taken only when a pop happens on the same cycle.
module i2c_cmd_fifo
   import i2c_seq_pkg::*;
#(
   parameter int DEPTH = DEF_DEPTH
) (
   input  logic clk,
   input  logic reset_n,
   input  logic push,
   input  cmd_t wr_data,
   input  logic pop,
   output cmd_t rd_data,
   output logic full,
   output logic empty
);

   localparam int AW = $clog2(DEPTH);

   cmd_t          mem [DEPTH];
   logic [AW:0]   wr_ptr;
   logic [AW:0]   rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign rd_data = mem[rd_ptr[AW-1:0]];

   // Pointer update; the extra MSB distinguishes full from empty
   always_ff @(posedge clk or posedge reset_n) begin
      // NOTE: clocked state always uses non-blocking assignments so every register sees pre-edge values.
      if (reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   // Entry storage
   always_ff @(posedge clk) begin
      // NOTE: the array is not reset on purpose; the pointers alone define which entries are valid.
      if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
   end

endmodule

// File: rtl/i2c_cmd_sequencer.sv
// I2C command sequencer: queues host commands and plays them one at a time
// into an i2c_top master, returning one in-order response per command.
// Optional WAIT_DONE watchdog is enabled with the macro I2C_SEQ_TIMEOUT_EN.
// reset_n is active-high despite its name.
module i2c_cmd_sequencer
   import i2c_seq_pkg::*;
#(
   parameter int DEPTH          = DEF_DEPTH,
   parameter int GAP_CYCLES     = DEF_GAP_CYCLES,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic       cmd_wr,
   input  logic [6:0] cmd_addr,
   input  logic [7:0] cmd_data,
   input  logic [2:0] cmd_mode,
   output logic       Master_EN,
   output logic       wr_rdn_en,
   output logic [7:0] input_data,
   output logic [6:0] addr,
   output logic [2:0] S,
   input  logic [7:0] data_out,
   input  logic       done,
   output logic       rsp_valid,
   input  logic       rsp_ready,
   output logic [7:0] rsp_data,
   output logic       rsp_wr,
   output logic       rsp_err,
   output logic       busy
);

   localparam int             GW       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [GW-1:0]  GAP_LAST = GW'(GAP_CYCLES - 1);

   state_t        state;
   cmd_t          cur_cmd;
   cmd_t          head;
   cmd_t          new_cmd;
   logic          fifo_full;
   logic          fifo_empty;
   logic          fifo_pop;
   logic          ready_en;
   logic [GW-1:0] gap_cnt;

`ifdef I2C_SEQ_TIMEOUT_EN
   localparam int             TW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TW-1:0]  TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
   logic [TW-1:0] tmo_cnt;
   logic          rsp_err_q;
   assign rsp_err = rsp_err_q;
`else
   assign rsp_err = 1'b0;
`endif

   assign new_cmd   = '{wr: cmd_wr, addr: cmd_addr, data: cmd_data, mode: cmd_mode};
   assign cmd_ready = ready_en && !fifo_full;
   assign fifo_pop  = (state == IDLE) && !fifo_empty && !done;
   assign busy      = (state != IDLE) || !fifo_empty;

   i2c_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (cmd_valid && cmd_ready),
      .wr_data (new_cmd),
      .pop     (fifo_pop),
      .rd_data (head),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   // Hold cmd_ready low through reset, open it from the first edge after release
   always_ff @(posedge clk or posedge reset_n) begin
      if (reset_n) ready_en <= 1'b0;
      else         ready_en <= 1'b1;
   end

   // Command FSM: pop, launch, wait for completion, respond, then hold the bus gap
   always_ff @(posedge clk or posedge reset_n) begin
      if (reset_n) begin
         state      <= IDLE;
         cur_cmd    <= '0;
         gap_cnt    <= '0;
         Master_EN  <= 1'b0;
         wr_rdn_en  <= 1'b0;
         input_data <= '0;
         addr       <= '0;
         S          <= '0;
         rsp_valid  <= 1'b0;
         rsp_data   <= '0;
         rsp_wr     <= 1'b0;
`ifdef I2C_SEQ_TIMEOUT_EN
         tmo_cnt    <= '0;
         rsp_err_q  <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (fifo_pop) begin
                  cur_cmd <= head;
                  state   <= LAUNCH;
               end
            end
            LAUNCH: begin
               addr       <= cur_cmd.addr;
               S          <= cur_cmd.mode;
               wr_rdn_en  <= cur_cmd.wr;
               input_data <= cur_cmd.wr ? cur_cmd.data : 8'h00;
               Master_EN  <= 1'b1;
`ifdef I2C_SEQ_TIMEOUT_EN
               tmo_cnt    <= '0;
`endif
               state      <= WAIT_DONE;
            end
            WAIT_DONE: begin
               if (done) begin
                  Master_EN <= 1'b0;
                  rsp_valid <= 1'b1;
                  rsp_wr    <= cur_cmd.wr;
                  rsp_data  <= cur_cmd.wr ? 8'h00 : data_out;
`ifdef I2C_SEQ_TIMEOUT_EN
                  rsp_err_q <= 1'b0;
`endif
                  state     <= RESP;
               end
`ifdef I2C_SEQ_TIMEOUT_EN
               else if (tmo_cnt == TMO_LAST) begin
                  Master_EN <= 1'b0;
                  rsp_valid <= 1'b1;
                  rsp_wr    <= cur_cmd.wr;
                  rsp_data  <= 8'h00;
                  rsp_err_q <= 1'b1;
                  state     <= RESP;
               end else begin
                  tmo_cnt <= tmo_cnt + TW'(1);
               end
`endif
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  gap_cnt   <= '0;
                  state     <= GAP;
               end
            end
            GAP: begin
               if (gap_cnt == GAP_LAST) state <= IDLE;
               else                     gap_cnt <= gap_cnt + GW'(1);
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
// Directed self-checking bench for i2c_cmd_sequencer with a small i2c_top stand-in.
module tb_i2c_cmd_sequencer;

   logic       clk = 1'b0;
   logic       reset_n = 1'b1;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic       cmd_wr = 1'b0;
   logic [6:0] cmd_addr = '0;
   logic [7:0] cmd_data = '0;
   logic [2:0] cmd_mode = '0;
   logic       Master_EN;
   logic       wr_rdn_en;
   logic [7:0] input_data;
   logic [6:0] addr;
   logic [2:0] S;
   logic [7:0] data_out = '0;
   logic       done;
   logic       rsp_valid;
   logic       rsp_ready = 1'b0;
   logic [7:0] rsp_data;
   logic       rsp_wr;
   logic       rsp_err;
   logic       busy;

   logic       model_en = 1'b1;
   logic       model_done = 1'b0;
   logic       tb_done = 1'b0;
   logic [7:0] mem [128];
   int         lat_cnt = 0;
   int         low_run = 0;
   int         last_gap = 0;
   int         n_assert = 0;
   int         n_fail = 0;

   assign done = model_done | tb_done;

   always #5 clk = ~clk;

   i2c_cmd_sequencer #(
      .DEPTH          (4),
      .GAP_CYCLES     (50),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_wr     (cmd_wr),
      .cmd_addr   (cmd_addr),
      .cmd_data   (cmd_data),
      .cmd_mode   (cmd_mode),
      .Master_EN  (Master_EN),
      .wr_rdn_en  (wr_rdn_en),
      .input_data (input_data),
      .addr       (addr),
      .S          (S),
      .data_out   (data_out),
      .done       (done),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_data   (rsp_data),
      .rsp_wr     (rsp_wr),
      .rsp_err    (rsp_err),
      .busy       (busy)
   );

   // i2c_top stand-in: byte memory, done pulse three cycles after Master_EN rises
   initial foreach (mem[i]) mem[i] = 8'h00;

   always @(negedge clk) begin
      if (model_en && Master_EN && !model_done) begin
         lat_cnt++;
         if (lat_cnt == 3) begin
            lat_cnt    = 0;
            model_done = 1'b1;
            if (wr_rdn_en) mem[addr] = input_data;
            else           data_out  = mem[addr];
         end
      end else begin
         model_done = 1'b0;
         if (!Master_EN) lat_cnt = 0;
      end
   end

   // Length of the most recent Master_EN low interval, in cycles
   always @(negedge clk) begin
      if (Master_EN) begin
         if (low_run != 0) last_gap = low_run;
         low_run = 0;
      end else begin
         low_run++;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic push(input logic wr, input logic [6:0] a, input logic [7:0] d, input logic [2:0] m);
      int n = 0;
      cmd_wr    = wr;
      cmd_addr  = a;
      cmd_data  = d;
      cmd_mode  = m;
      cmd_valid = 1'b1;
      while (!cmd_ready && n < 400) begin
         tick(1);
         n++;
      end
      if (n >= 400) check("push_ready_timeout", 16'(cmd_ready), 16'd1);
      tick(1);
      cmd_valid = 1'b0;
   endtask

   task automatic wait_launch(input string tag);
      int n = 0;
      while (!Master_EN && n < 200) begin
         tick(1);
         n++;
      end
      check(tag, 16'(Master_EN), 16'd1);
   endtask

   task automatic wait_valid(input string tag);
      int n = 0;
      while (!rsp_valid && n < 200) begin
         tick(1);
         n++;
      end
      check(tag, 16'(rsp_valid), 16'd1);
   endtask

   task automatic wait_rsp(input string tag, input logic wr, input logic [7:0] d, input logic err);
      wait_valid({tag, "_valid"});
      check({tag, "_wr"},   16'(rsp_wr),   16'(wr));
      check({tag, "_data"}, 16'(rsp_data), 16'(d));
      check({tag, "_err"},  16'(rsp_err),  16'(err));
      rsp_ready = 1'b1;
      tick(1);
      rsp_ready = 1'b0;
      check({tag, "_released"}, 16'(rsp_valid), 16'd0);
   endtask

   initial begin
      int n;
      logic saw;

      // Reset state
      @(posedge clk);
      #1;
      check("rst_master_en", 16'(Master_EN), 16'd0);
      check("rst_cmd_ready", 16'(cmd_ready), 16'd0);
      check("rst_rsp_valid", 16'(rsp_valid), 16'd0);
      check("rst_busy",      16'(busy),      16'd0);
      reset_n = 1'b0;
      tick(1);
      check("post_rst_cmd_ready", 16'(cmd_ready), 16'd1);

      // Write then read addr 0x15; launch latency from empty/IDLE is two edges
      push(1'b1, 7'h15, 8'h15, 3'd1);
      check("lat_e0_master_en", 16'(Master_EN), 16'd0);
      check("lat_e0_busy",      16'(busy),      16'd1);
      tick(1);
      check("lat_e1_master_en", 16'(Master_EN), 16'd0);
      tick(1);
      check("lat_e2_master_en", 16'(Master_EN),  16'd1);
      check("wr_addr",          16'(addr),       16'h15);
      check("wr_S",             16'(S),          16'd1);
      check("wr_dir",           16'(wr_rdn_en),  16'd1);
      check("wr_input_data",    16'(input_data), 16'h15);
      push(1'b0, 7'h15, 8'hAA, 3'd2);
      check("wait_master_en_held", 16'(Master_EN), 16'd1);
      check("wait_addr_held",      16'(addr),      16'h15);

      // Response stall: 20 cycles with rsp_ready low, read queued behind it
      wait_valid("stall_valid");
      for (int i = 0; i < 20; i++) begin
         tick(1);
         check("stall_rsp_valid", 16'(rsp_valid), 16'd1);
         check("stall_rsp_data",  16'(rsp_data),  16'h00);
         check("stall_rsp_wr",    16'(rsp_wr),    16'd1);
         check("stall_master_en", 16'(Master_EN), 16'd0);
      end
      wait_rsp("wr15_rsp", 1'b1, 8'h00, 1'b0);
      wait_launch("rd_launch");
      check("rd_dir",        16'(wr_rdn_en),  16'd0);
      check("rd_input_data", 16'(input_data), 16'h00);
      check("rd_addr",       16'(addr),       16'h15);
      check("rd_S",          16'(S),          16'd2);
      wait_rsp("rd15_rsp", 1'b0, 8'h15, 1'b0);

      // Gap between two queued writes: 1 RESP + 50 GAP + 1 IDLE + 1 LAUNCH = 53 cycles low
      push(1'b1, 7'h30, 8'h5A, 3'd0);
      push(1'b1, 7'h31, 8'hA5, 3'd0);
      wait_rsp("gap_w1", 1'b1, 8'h00, 1'b0);
      wait_launch("gap_w2_launch");
      @(negedge clk);
      #1;
      check("gap_len", 16'(last_gap), 16'd53);
      wait_rsp("gap_w2", 1'b1, 8'h00, 1'b0);

      // done held high in IDLE blocks the pop and is otherwise ignored
      tick(55);
      tb_done = 1'b1;
      push(1'b1, 7'h40, 8'h01, 3'd0);
      tick(4);
      check("done_hi_master_en", 16'(Master_EN), 16'd0);
      check("done_hi_busy",      16'(busy),      16'd1);
      check("done_hi_rsp_valid", 16'(rsp_valid), 16'd0);
      tb_done = 1'b0;
      tick(2);
      check("done_lo_launch", 16'(Master_EN), 16'd1);
      wait_rsp("done_hold_rsp", 1'b1, 8'h00, 1'b0);

      // Back-pressure: A in WAIT_DONE, B..E fill the FIFO, F waits for space
      model_en = 1'b0;
      push(1'b1, 7'h20, 8'h11, 3'd0);
      wait_launch("bp_a_launch");
      push(1'b1, 7'h21, 8'h22, 3'd0);
      push(1'b0, 7'h20, 8'h00, 3'd0);
      push(1'b0, 7'h21, 8'h00, 3'd0);
      push(1'b1, 7'h20, 8'h33, 3'd0);
      check("bp_full_ready", 16'(cmd_ready), 16'd0);
      tick(5);
      check("bp_ready_stays_low", 16'(cmd_ready),  16'd0);
      check("bp_master_en_held",  16'(Master_EN),  16'd1);
      check("bp_addr_held",       16'(addr),       16'h20);
      check("bp_data_held",       16'(input_data), 16'h11);
      model_en = 1'b1;
      wait_rsp("bp_a", 1'b1, 8'h00, 1'b0);
      push(1'b0, 7'h20, 8'h00, 3'd0);
      wait_rsp("bp_b", 1'b1, 8'h00, 1'b0);
      wait_rsp("bp_c", 1'b0, 8'h11, 1'b0);
      wait_rsp("bp_d", 1'b0, 8'h22, 1'b0);
      wait_rsp("bp_e", 1'b1, 8'h00, 1'b0);
      wait_rsp("bp_f", 1'b0, 8'h33, 1'b0);

`ifdef I2C_SEQ_TIMEOUT_EN
      // Timeout: done never arrives, abort after 16 WAIT_DONE cycles
      model_en = 1'b0;
      push(1'b0, 7'h50, 8'h00, 3'd0);
      wait_launch("tmo_launch");
      n = 0;
      while (!rsp_valid && n < 100) begin
         tick(1);
         n++;
      end
      check("tmo_cycles", 16'(n), 16'd16);
      wait_rsp("tmo_rsp", 1'b0, 8'h00, 1'b1);
      model_en = 1'b1;
      push(1'b1, 7'h51, 8'h77, 3'd0);
      wait_launch("tmo_next_launch");
      check("tmo_next_addr", 16'(addr), 16'h51);
      wait_rsp("tmo_next_rsp", 1'b1, 8'h00, 1'b0);
`endif

      // Reset during WAIT_DONE with one more command queued
      model_en = 1'b0;
      push(1'b1, 7'h60, 8'h01, 3'd0);
      wait_launch("rst_launch");
      push(1'b1, 7'h61, 8'h02, 3'd0);
      reset_n = 1'b1;
      #1;
      check("midrst_master_en", 16'(Master_EN), 16'd0);
      check("midrst_cmd_ready", 16'(cmd_ready), 16'd0);
      check("midrst_busy",      16'(busy),      16'd0);
      check("midrst_rsp_valid", 16'(rsp_valid), 16'd0);
      @(posedge clk);
      #1;
      reset_n = 1'b0;
      tick(1);
      check("postrst_cmd_ready", 16'(cmd_ready), 16'd1);
      check("postrst_busy",      16'(busy),      16'd0);
      model_en = 1'b1;
      saw = 1'b0;
      for (int i = 0; i < 80; i++) begin
         tick(1);
         if (rsp_valid || Master_EN) saw = 1'b1;
      end
      check("postrst_no_activity", 16'(saw), 16'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
